// File: rtl/ftsd_stopwatch_core_pkg.sv
// Shared encodings for the MM:SS stopwatch
// and the downstream 14-segment scan mux.
package ftsd_stopwatch_core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX9 = 4'd9;
  localparam logic [3:0] BCD_MAX5 = 4'd5;

  localparam logic [1:0] SCAN_SEL_D0 = 2'b00;
  localparam logic [1:0] SCAN_SEL_D1 = 2'b01;
  localparam logic [1:0] SCAN_SEL_D2 = 2'b10;
  localparam logic [1:0] SCAN_SEL_D3 = 2'b11;

endpackage

// File: rtl/ftsd_stopwatch_core_bcd_digit_counter.sv
// One BCD digit 0..MAX; carry is combinational
// so a whole cascade rolls over on a single edge.
module bcd_digit_counter
  import ftsd_stopwatch_core_pkg::*;
#(
  parameter logic [3:0] MAX = BCD_MAX9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] value,
  output logic       carry
);

  assign carry = inc && (value == MAX);

  // count up on inc, fold back to 0 past MAX
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= 4'd0;
    end else if (inc) begin
      value <= carry ? 4'd0 : value + 4'd1;
    end
  end

endmodule

// File: rtl/ftsd_stopwatch_core.sv
// MM:SS stopwatch: run/pause FSM, second prescaler,
// BCD digit cascade and free-running scan divider.
module ftsd_stopwatch_core
  import ftsd_stopwatch_core_pkg::*;
#(
  parameter int SEC_DIV   = 40000000,
  parameter int SCAN_BITS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [1:0] scan_sel,
  output logic       running,
  output logic       wrap
);

  localparam int PW = $clog2(SEC_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(SEC_DIV - 1);

  state_t               state;
  state_t               state_nx;
  logic [PW-1:0]        presc;
  logic [SCAN_BITS-1:0] scan_div;
  logic                 tick;
  logic                 c3;
  logic                 c2;
  logic                 c1;
  logic                 c0;

  assign tick     = (state == ST_RUN) && (presc == PRE_MAX);
  assign scan_sel = scan_div[SCAN_BITS-1 -: 2];

  // next state: clear beats start_stop
  always_comb begin
    state_nx = state;
    if (clear) begin
      state_nx = ST_IDLE;
    end else if (start_stop) begin
      unique case (state)
        ST_IDLE:  state_nx = ST_RUN;
        ST_RUN:   state_nx = ST_PAUSE;
        ST_PAUSE: state_nx = ST_RUN;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  // state register and its registered RUN flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      running <= 1'b0;
    end else begin
      state   <= state_nx;
      running <= (state_nx == ST_RUN);
    end
  end

  // prescaler: counts in RUN, holds in PAUSE
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      presc <= '0;
    end else if (state == ST_RUN) begin
      presc <= tick ? '0 : presc + 1'b1;
    end
  end

  // scan divider ignores everything but rst
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_div <= '0;
    end else begin
      scan_div <= scan_div + 1'b1;
    end
  end

  // wrap marks the 59:59 -> 00:00 edge
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wrap <= 1'b0;
    end else begin
      wrap <= c0;
    end
  end

  bcd_digit_counter #(.MAX(BCD_MAX9)) u_sec (
    .clk  (clk),
    .rst  (rst),
    .clr  (clear),
    .inc  (tick),
    .value(digit3),
    .carry(c3)
  );

  bcd_digit_counter #(.MAX(BCD_MAX5)) u_tsec (
    .clk  (clk),
    .rst  (rst),
    .clr  (clear),
    .inc  (c3),
    .value(digit2),
    .carry(c2)
  );

  bcd_digit_counter #(.MAX(BCD_MAX9)) u_min (
    .clk  (clk),
    .rst  (rst),
    .clr  (clear),
    .inc  (c2),
    .value(digit1),
    .carry(c1)
  );

  bcd_digit_counter #(.MAX(BCD_MAX5)) u_tmin (
    .clk  (clk),
    .rst  (rst),
    .clr  (clear),
    .inc  (c1),
    .value(digit0),
    .carry(c0)
  );

endmodule

// File: tb/tb_ftsd_stopwatch_core.sv
// Directed bench for the MM:SS stopwatch core
// with SEC_DIV=4 and SCAN_BITS=2.
module tb_ftsd_stopwatch_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [1:0] scan_sel;
  logic       running;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  logic [1:0]  exp_scan;
  logic [15:0] t_obs;

  assign t_obs = {digit0, digit1, digit2, digit3};

  ftsd_stopwatch_core #(
    .SEC_DIV  (4),
    .SCAN_BITS(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_stop(start_stop),
    .clear     (clear),
    .digit0    (digit0),
    .digit1    (digit1),
    .digit2    (digit2),
    .digit3    (digit3),
    .scan_sel  (scan_sel),
    .running   (running),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  // reference scan divider
  always @(posedge clk) begin
    if (rst) exp_scan <= 2'd0;
    else exp_scan <= exp_scan + 2'd1;
  end

  function automatic logic [15:0] mmss(input int s);
    mmss = {4'(s / 600), 4'((s / 60) % 10),
            4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic pulse(input logic ss, input logic cl);
    start_stop = ss;
    clear = cl;
    cyc(1);
    start_stop = 1'b0;
    clear = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc(2);
    checks++;
    if (t_obs !== 16'h0000 || running !== 1'b0 ||
        wrap !== 1'b0 || scan_sel !== 2'd0) begin
      errors++;
      $display("FAIL reset: t=%h run=%b wrap=%b sel=%0d want 0000/0/0/0",
               t_obs, running, wrap, scan_sel);
    end
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cyc(1);
      checks++;
      if (scan_sel !== 2'(i % 4) || t_obs !== 16'h0000 ||
          running !== 1'b0) begin
        errors++;
        $display("FAIL idle_scan %0d: sel=%0d t=%h run=%b want sel=%0d t=0000 run=0",
                 i, scan_sel, t_obs, running, i % 4);
      end
    end
  endtask

  task automatic test_run;
    pulse(1'b1, 1'b0);
    checks++;
    if (running !== 1'b1 || t_obs !== 16'h0000) begin
      errors++;
      $display("FAIL run_entry: run=%b t=%h want 1/0000", running, t_obs);
    end
    for (int s = 1; s <= 10; s++) begin
      cyc(3);
      checks++;
      if (t_obs !== mmss(s - 1)) begin
        errors++;
        $display("FAIL run_hold %0d: t=%h want %h", s, t_obs, mmss(s - 1));
      end
      cyc(1);
      checks++;
      if (t_obs !== mmss(s) || running !== 1'b1) begin
        errors++;
        $display("FAIL run_tick %0d: t=%h run=%b want %h/1",
                 s, t_obs, running, mmss(s));
      end
    end
  endtask

  task automatic test_pause;
    cyc(1);
    pulse(1'b1, 1'b0);
    checks++;
    if (running !== 1'b0 || t_obs !== 16'h0010) begin
      errors++;
      $display("FAIL pause_entry: run=%b t=%h want 0/0010", running, t_obs);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(5);
      checks++;
      if (t_obs !== 16'h0010 || running !== 1'b0) begin
        errors++;
        $display("FAIL pause_hold %0d: t=%h run=%b want 0010/0",
                 i, t_obs, running);
      end
    end
    pulse(1'b1, 1'b0);
    checks++;
    if (running !== 1'b1 || t_obs !== 16'h0010) begin
      errors++;
      $display("FAIL resume: run=%b t=%h want 1/0010", running, t_obs);
    end
    cyc(1);
    checks++;
    if (t_obs !== 16'h0010) begin
      errors++;
      $display("FAIL resume_partial: t=%h want 0010", t_obs);
    end
    cyc(1);
    checks++;
    if (t_obs !== 16'h0011) begin
      errors++;
      $display("FAIL resume_tick: t=%h want 0011", t_obs);
    end
  endtask

  task automatic test_wrap;
    pulse(1'b0, 1'b1);
    checks++;
    if (t_obs !== 16'h0000 || running !== 1'b0) begin
      errors++;
      $display("FAIL clear: t=%h run=%b want 0000/0", t_obs, running);
    end
    pulse(1'b1, 1'b0);
    cyc(4 * 3598);
    checks++;
    if (t_obs !== 16'h5958 || running !== 1'b1) begin
      errors++;
      $display("FAIL preload: t=%h run=%b want 5958/1", t_obs, running);
    end
    cyc(4);
    checks++;
    if (t_obs !== 16'h5959 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL pre_wrap: t=%h wrap=%b want 5959/0", t_obs, wrap);
    end
    cyc(3);
    checks++;
    if (t_obs !== 16'h5959 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL pre_wrap_hold: t=%h wrap=%b want 5959/0", t_obs, wrap);
    end
    cyc(1);
    checks++;
    if (t_obs !== 16'h0000 || wrap !== 1'b1 || running !== 1'b1) begin
      errors++;
      $display("FAIL wrap: t=%h wrap=%b run=%b want 0000/1/1",
               t_obs, wrap, running);
    end
    cyc(1);
    checks++;
    if (t_obs !== 16'h0000 || wrap !== 1'b0 || running !== 1'b1) begin
      errors++;
      $display("FAIL wrap_pulse: t=%h wrap=%b run=%b want 0000/0/1",
               t_obs, wrap, running);
    end
  endtask

  task automatic test_clear_start;
    cyc(27);
    checks++;
    if (t_obs !== 16'h0007) begin
      errors++;
      $display("FAIL at_0007: t=%h want 0007", t_obs);
    end
    cyc(2);
    pulse(1'b1, 1'b1);
    checks++;
    if (t_obs !== 16'h0000 || running !== 1'b0 || wrap !== 1'b0 ||
        scan_sel !== exp_scan) begin
      errors++;
      $display("FAIL clear_wins: t=%h run=%b wrap=%b sel=%0d want 0000/0/0/%0d",
               t_obs, running, wrap, scan_sel, exp_scan);
    end
    cyc(5);
    checks++;
    if (t_obs !== 16'h0000 || running !== 1'b0 || scan_sel !== exp_scan) begin
      errors++;
      $display("FAIL idle_after_clear: t=%h run=%b sel=%0d want 0000/0/%0d",
               t_obs, running, scan_sel, exp_scan);
    end
    pulse(1'b1, 1'b0);
    cyc(3);
    checks++;
    if (t_obs !== 16'h0000 || running !== 1'b1) begin
      errors++;
      $display("FAIL restart_hold: t=%h run=%b want 0000/1", t_obs, running);
    end
    cyc(1);
    checks++;
    if (t_obs !== 16'h0001) begin
      errors++;
      $display("FAIL restart_tick: t=%h want 0001", t_obs);
    end
  endtask

  task automatic test_rst_mid;
    cyc(82 * 4);
    checks++;
    if (t_obs !== 16'h0123 || running !== 1'b1) begin
      errors++;
      $display("FAIL at_0123: t=%h run=%b want 0123/1", t_obs, running);
    end
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    checks++;
    if (t_obs !== 16'h0000 || running !== 1'b0 || wrap !== 1'b0 ||
        scan_sel !== 2'd0) begin
      errors++;
      $display("FAIL mid_rst: t=%h run=%b wrap=%b sel=%0d want 0000/0/0/0",
               t_obs, running, wrap, scan_sel);
    end
    cyc(3);
    checks++;
    if (t_obs !== 16'h0000 || running !== 1'b0 || scan_sel !== 2'd3) begin
      errors++;
      $display("FAIL post_rst: t=%h run=%b sel=%0d want 0000/0/3",
               t_obs, running, scan_sel);
    end
  endtask

  task automatic test_back_to_back;
    start_stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      checks++;
      if (running !== 1'(~i[0])) begin
        errors++;
        $display("FAIL held_ss %0d: run=%b want %b", i, running, ~i[0]);
      end
    end
    start_stop = 1'b0;
  endtask

  initial begin
    test_reset;
    test_run;
    test_pause;
    test_wrap;
    test_clear_start;
    test_rst_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
